// File: rtl/nasti_ddrx_pkg.sv
// Shared types for the NASTI-to-DDR path: FIFO transaction records and the
// scheduler state encoding.
package nasti_ddrx_pkg;

    localparam int unsigned NASTI_ID_W   = 9;
    localparam int unsigned NASTI_ADDR_W = 32;
    localparam int unsigned NASTI_DATA_W = 64;

    typedef struct packed {
        logic [NASTI_ID_W-1:0]   id;
        logic [NASTI_ADDR_W-1:0] addr;
        logic [7:0]              len;
    } ar_trans;

    typedef struct packed {
        logic [NASTI_ID_W-1:0]   id;
        logic [NASTI_ADDR_W-1:0] addr;
        logic [7:0]              len;
    } aw_trans;

    typedef struct packed {
        logic [NASTI_DATA_W-1:0]   data;
        logic [NASTI_DATA_W/8-1:0] strb;
        logic                      last;
    } w_trans;

    typedef enum logic [1:0] {
        IDLE,
        RD_CMD,
        WR_CMD,
        WR_DATA
    } sched_state_e;

endpackage

// File: rtl/nasti_sched_arb.sv
// Read-priority grant with a bounded run of reads while a write waits.
module nasti_sched_arb #(
    parameter int unsigned C_MAX_STARVE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic rempty_ar,
    input  logic rempty_aw,
    output logic grant_rd,
    output logic grant_wr
);

    localparam logic [7:0] MAX_STARVE = 8'(C_MAX_STARVE);

    logic [7:0] starve_q, starve_d;

    always_comb begin
        grant_wr = en && !rempty_aw && (rempty_ar || (starve_q == MAX_STARVE));
        grant_rd = en && !rempty_ar && !grant_wr;
        starve_d = starve_q;
        if (grant_wr) begin
            starve_d = '0;
        end else if (grant_rd && !rempty_aw && (starve_q < MAX_STARVE)) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/nasti_rw_scheduler.sv
// Pops AR/AW/W FIFOs, issues one burst command at a time to the DDR backend
// and streams the write beats, flagging W bursts whose last disagrees with AWLEN.
module nasti_rw_scheduler
    import nasti_ddrx_pkg::*;
#(
    parameter int unsigned C_NASTI_ID_WIDTH   = 9,
    parameter int unsigned C_NASTI_ADDR_WIDTH = 32,
    parameter int unsigned C_NASTI_DATA_WIDTH = 64,
    parameter int unsigned C_MAX_STARVE       = 8
) (
    input  logic                            core_clk,
    input  logic                            core_arstn,
    input  ar_trans                         rdata_ar,
    input  logic                            rempty_ar,
    output logic                            rinc_ar,
    input  aw_trans                         rdata_aw,
    input  logic                            rempty_aw,
    output logic                            rinc_aw,
    input  w_trans                          rdata_w,
    input  logic                            rempty_w,
    output logic                            rinc_w,
    output logic                            cmd_valid,
    input  logic                            cmd_ready,
    output logic                            cmd_write,
    output logic [C_NASTI_ID_WIDTH-1:0]     cmd_id,
    output logic [C_NASTI_ADDR_WIDTH-1:0]   cmd_addr,
    output logic [7:0]                      cmd_len,
    output logic                            wd_valid,
    input  logic                            wd_ready,
    output logic [C_NASTI_DATA_WIDTH-1:0]   wd_data,
    output logic [C_NASTI_DATA_WIDTH/8-1:0] wd_strb,
    output logic                            wd_last,
    output logic                            wr_err
);

    sched_state_e                    state_q, state_d;
    logic [C_NASTI_ID_WIDTH-1:0]     id_q, id_d;
    logic [C_NASTI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]                      len_q, len_d;
    logic [7:0]                      beat_q, beat_d;
    logic                            err_q, err_d;
    logic                            grant_rd, grant_wr;

    nasti_sched_arb #(
        .C_MAX_STARVE(C_MAX_STARVE)
    ) u_arb (
        .clk      (core_clk),
        .rst_n    (core_arstn),
        .en       (state_q == IDLE),
        .rempty_ar(rempty_ar),
        .rempty_aw(rempty_aw),
        .grant_rd (grant_rd),
        .grant_wr (grant_wr)
    );

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        err_d     = err_q;
        rinc_ar   = grant_rd;
        rinc_aw   = grant_wr;
        rinc_w    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        wd_valid  = 1'b0;
        wd_data   = '0;
        wd_strb   = '0;
        wd_last   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_rd) begin
                    state_d = RD_CMD;
                    id_d    = rdata_ar.id;
                    addr_d  = rdata_ar.addr;
                    len_d   = rdata_ar.len;
                    beat_d  = '0;
                end else if (grant_wr) begin
                    state_d = WR_CMD;
                    id_d    = rdata_aw.id;
                    addr_d  = rdata_aw.addr;
                    len_d   = rdata_aw.len;
                    beat_d  = '0;
                end
            end
            RD_CMD: begin
                cmd_valid = 1'b1;
                if (cmd_ready) state_d = IDLE;
            end
            WR_CMD: begin
                cmd_valid = 1'b1;
                cmd_write = 1'b1;
                if (cmd_ready) state_d = WR_DATA;
            end
            WR_DATA: begin
                wd_valid = !rempty_w;
                wd_data  = rdata_w.data;
                wd_strb  = rdata_w.strb;
                wd_last  = (beat_q == len_q);
                rinc_w   = wd_valid && wd_ready;
                // Burst length is owned by AWLEN; W last is only cross-checked.
                if (rinc_w) begin
                    beat_d = beat_q + 8'd1;
                    if (rdata_w.last != wd_last) err_d = 1'b1;
                    if (wd_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    assign cmd_id   = id_q;
    assign cmd_addr = addr_q;
    assign cmd_len  = len_q;
    assign wr_err   = err_q;

endmodule

// File: tb/tb_nasti_rw_scheduler.sv
// Directed bench for nasti_rw_scheduler: FIFO models feed the DUT, a monitor
// logs handshakes, and tables plus hand sequences compare against fixed values.
`timescale 1ns/1ps
module tb_nasti_rw_scheduler;
    import nasti_ddrx_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    ar_trans     rdata_ar;
    aw_trans     rdata_aw;
    w_trans      rdata_w;
    logic        rempty_ar, rempty_aw, rempty_w;
    logic        rinc_ar, rinc_aw, rinc_w;
    logic        cmd_valid, cmd_write;
    logic        cmd_ready = 1'b0;
    logic [8:0]  cmd_id;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wd_valid, wd_last, wr_err;
    logic        wd_ready = 1'b0;
    logic [63:0] wd_data;
    logic [7:0]  wd_strb;

    always #5 clk = ~clk;

    nasti_rw_scheduler #(
        .C_NASTI_ID_WIDTH(9), .C_NASTI_ADDR_WIDTH(32),
        .C_NASTI_DATA_WIDTH(64), .C_MAX_STARVE(2)
    ) dut (
        .core_clk(clk), .core_arstn(rst_n),
        .rdata_ar(rdata_ar), .rempty_ar(rempty_ar), .rinc_ar(rinc_ar),
        .rdata_aw(rdata_aw), .rempty_aw(rempty_aw), .rinc_aw(rinc_aw),
        .rdata_w(rdata_w), .rempty_w(rempty_w), .rinc_w(rinc_w),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .wd_strb(wd_strb), .wd_last(wd_last), .wr_err(wr_err)
    );

    // FIFO models: writer pointers owned by the stimulus, reader pointers by the monitor
    ar_trans     ar_mem [64];
    aw_trans     aw_mem [64];
    w_trans      w_mem  [64];
    int unsigned ar_wp = 0, aw_wp = 0, w_wp = 0;
    int unsigned ar_rp = 0, aw_rp = 0, w_rp = 0;

    assign rdata_ar  = ar_mem[ar_rp % 64];
    assign rdata_aw  = aw_mem[aw_rp % 64];
    assign rdata_w   = w_mem[w_rp % 64];
    assign rempty_ar = (ar_rp == ar_wp);
    assign rempty_aw = (aw_rp == aw_wp);
    assign rempty_w  = (w_rp == w_wp);

    int unsigned viol = 0;
    int unsigned beat_n = 0, cmd_n = 0;
    logic [63:0] b_data  [64];
    logic        b_last  [64];
    logic        b_wlast [64];
    logic        c_write [64];
    logic [8:0]  c_id    [64];

    always @(posedge clk) begin
        if ((rinc_ar && rempty_ar) || (rinc_aw && rempty_aw) || (rinc_w && rempty_w))
            viol <= viol + 1;
        if (rinc_ar) ar_rp <= ar_rp + 1;
        if (rinc_aw) aw_rp <= aw_rp + 1;
        if (rinc_w)  w_rp  <= w_rp + 1;
        if (wd_valid && wd_ready) begin
            b_data[beat_n % 64]  <= wd_data;
            b_last[beat_n % 64]  <= wd_last;
            b_wlast[beat_n % 64] <= rdata_w.last;
            beat_n <= beat_n + 1;
        end
        if (cmd_valid && cmd_ready) begin
            c_write[cmd_n % 64] <= cmd_write;
            c_id[cmd_n % 64]    <= cmd_id;
            cmd_n <= cmd_n + 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ar(input logic [8:0] id, input logic [31:0] addr, input logic [7:0] len);
        ar_mem[ar_wp % 64].id   = id;
        ar_mem[ar_wp % 64].addr = addr;
        ar_mem[ar_wp % 64].len  = len;
        ar_wp = ar_wp + 1;
    endtask

    task automatic push_aw(input logic [8:0] id, input logic [31:0] addr, input logic [7:0] len);
        aw_mem[aw_wp % 64].id   = id;
        aw_mem[aw_wp % 64].addr = addr;
        aw_mem[aw_wp % 64].len  = len;
        aw_wp = aw_wp + 1;
    endtask

    task automatic push_w(input logic [63:0] data, input logic last);
        w_mem[w_wp % 64].data = data;
        w_mem[w_wp % 64].strb = data[7:0];
        w_mem[w_wp % 64].last = last;
        w_wp = w_wp + 1;
    endtask

    task automatic wait_beats(input int unsigned n, input string name);
        int c = 0;
        while (beat_n < n && c < 200) begin @(negedge clk); #1; c++; end
        chk(name, beat_n, n);
    endtask

    task automatic wait_cmds(input int unsigned n, input string name);
        int c = 0;
        while (cmd_n < n && c < 200) begin @(negedge clk); #1; c++; end
        chk(name, cmd_n, n);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rinc"}, {rinc_ar, rinc_aw, rinc_w}, 0);
        chk({tag, "_cmd_ctl"}, {cmd_valid, cmd_write}, 0);
        chk({tag, "_cmd_id"}, cmd_id, 0);
        chk({tag, "_cmd_addr"}, cmd_addr, 0);
        chk({tag, "_cmd_len"}, cmd_len, 0);
        chk({tag, "_wd_ctl"}, {wd_valid, wd_last, wr_err}, 0);
        chk({tag, "_wd_data"}, wd_data, 0);
        chk({tag, "_wd_strb"}, wd_strb, 0);
    endtask

    typedef struct {
        logic [8:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [8:0]  exp_id;
        logic [31:0] exp_addr;
        logic [7:0]  exp_len;
    } rd_vec_t;

    rd_vec_t rd_tab [4];

    initial begin
        int unsigned b0, c0, p0;
        logic [63:0] exp_d [4];

        rd_tab[0] = '{9'd5,   32'h0000_0100, 8'd3,   9'd5,   32'h0000_0100, 8'd3};
        rd_tab[1] = '{9'h1FF, 32'hFFFF_FFFC, 8'd255, 9'h1FF, 32'hFFFF_FFFC, 8'd255};
        rd_tab[2] = '{9'd0,   32'h0000_0000, 8'd0,   9'd0,   32'h0000_0000, 8'd0};
        rd_tab[3] = '{9'h0AA, 32'h8000_0000, 8'd1,   9'h0AA, 32'h8000_0000, 8'd1};

        repeat (2) @(negedge clk);
        #1 chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cmd_ready = 1'b1;

        // single reads: grant in the push cycle, command on the next
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            p0 = ar_rp;
            push_ar(rd_tab[i].id, rd_tab[i].addr, rd_tab[i].len);
            #1;
            chk("rd_rinc_ar", rinc_ar, 1);
            chk("rd_pre_valid", cmd_valid, 0);
            @(negedge clk); #1;
            chk("rd_cmd_valid", cmd_valid, 1);
            chk("rd_cmd_write", cmd_write, 0);
            chk("rd_cmd_id", cmd_id, rd_tab[i].exp_id);
            chk("rd_cmd_addr", cmd_addr, rd_tab[i].exp_addr);
            chk("rd_cmd_len", cmd_len, rd_tab[i].exp_len);
            chk("rd_rinc_ar_off", rinc_ar, 0);
            @(negedge clk); #1;
            chk("rd_done_valid", cmd_valid, 0);
            chk("rd_pops", ar_rp - p0, 1);
        end

        // single write, 4 beats
        @(negedge clk);
        b0 = beat_n; p0 = w_rp;
        wd_ready = 1'b1;
        push_aw(9'd2, 32'h40, 8'd3);
        for (int i = 0; i < 4; i++) push_w(64'h1000 + 64'(i), i == 3);
        #1;
        chk("wr_rinc_aw", rinc_aw, 1);
        @(negedge clk); #1;
        chk("wr_cmd_ctl", {cmd_valid, cmd_write}, 2'b11);
        chk("wr_cmd_id", cmd_id, 2);
        chk("wr_cmd_addr", cmd_addr, 32'h40);
        chk("wr_cmd_len", cmd_len, 3);
        chk("wr_no_beat_yet", wd_valid, 0);
        wait_beats(b0 + 4, "wr_beats");
        for (int i = 0; i < 4; i++) begin
            chk("wr_beat_data", b_data[(b0 + i) % 64], 64'h1000 + 64'(i));
            chk("wr_beat_last", b_last[(b0 + i) % 64], i == 3);
        end
        chk("wr_pops_w", w_rp - p0, 4);
        chk("wr_end_valid", wd_valid, 0);
        chk("wr_err_clean", wr_err, 0);

        // starvation bound 2: R R W R R R
        @(negedge clk);
        c0 = cmd_n;
        for (int i = 0; i < 5; i++) push_ar(9'd10 + 9'(i), 32'h0, 8'd0);
        push_aw(9'd20, 32'h0, 8'd0);
        push_w(64'h55, 1'b1);
        wait_cmds(c0 + 6, "starve_cmds");
        for (int i = 0; i < 6; i++)
            chk("starve_order", c_write[(c0 + i) % 64], i == 2);

        // command backpressure
        @(negedge clk);
        cmd_ready = 1'b0;
        c0 = cmd_n; p0 = ar_rp;
        push_ar(9'd7, 32'h700, 8'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) push_ar(9'd8, 32'h800, 8'd1);
            #1;
            chk("bp_valid", cmd_valid, 1);
            chk("bp_fields", {cmd_id, cmd_addr, cmd_len}, {9'd7, 32'h700, 8'd2});
            chk("bp_no_rinc", rinc_ar, 0);
        end
        cmd_ready = 1'b1;
        wait_cmds(c0 + 2, "bp_cmds");
        chk("bp_id0", c_id[c0 % 64], 7);
        chk("bp_id1", c_id[(c0 + 1) % 64], 8);
        chk("bp_pops", ar_rp - p0, 2);

        // wd_ready toggling with the W FIFO running dry mid-burst
        @(negedge clk);
        wd_ready = 1'b0;
        b0 = beat_n; p0 = w_rp;
        for (int i = 0; i < 4; i++) exp_d[i] = 64'hA0 + 64'(i);
        push_aw(9'd9, 32'h900, 8'd3);
        push_w(exp_d[0], 1'b0);
        push_w(exp_d[1], 1'b0);
        for (int c = 0; c < 100 && beat_n < b0 + 4; c++) begin
            @(negedge clk);
            wd_ready = ~wd_ready;
            if (c == 12) begin push_w(exp_d[2], 1'b0); push_w(exp_d[3], 1'b1); end
        end
        #1;
        chk("tog_beats", beat_n, b0 + 4);
        for (int i = 0; i < 4; i++) begin
            chk("tog_data", b_data[(b0 + i) % 64], exp_d[i]);
            chk("tog_last", b_last[(b0 + i) % 64], i == 3);
        end
        chk("tog_pops_w", w_rp - p0, 4);
        chk("tog_err", wr_err, 0);

        // length mismatch: len=1 but W last on beat 0
        @(negedge clk);
        wd_ready = 1'b1;
        b0 = beat_n; p0 = w_rp;
        push_aw(9'd1, 32'h80, 8'd1);
        push_w(64'hB0, 1'b1);
        push_w(64'hB1, 1'b0);
        wait_beats(b0 + 1, "len_beat0");
        chk("len_err_set", wr_err, 1);
        wait_beats(b0 + 2, "len_beats");
        chk("len_pops_w", w_rp - p0, 2);
        push_w(64'hEE, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("len_ended", {wd_valid, rinc_w}, 0);
        chk("len_beat_count", beat_n, b0 + 2);
        chk("len_err_sticky", wr_err, 1);

        // reset after one beat of an 8-beat write
        @(negedge clk);
        b0 = beat_n; p0 = w_rp;
        push_aw(9'd3, 32'h200, 8'd7);
        push_w(64'hC1, 1'b0);
        wait_beats(b0 + 1, "rst_first_beat");
        rst_n = 1'b0;
        #1 chk_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_idle", {wd_valid, rinc_w, cmd_valid}, 0);
        chk("rst_pops_w", w_rp - p0, 1);
        @(negedge clk);
        b0 = beat_n; c0 = cmd_n;
        push_aw(9'd4, 32'h300, 8'd1);
        push_w(64'hD1, 1'b1);
        wait_beats(b0 + 2, "post_rst_beats");
        chk("post_rst_cmd", {c_write[c0 % 64], c_id[c0 % 64]}, {1'b1, 9'd4});
        chk("post_rst_d0", b_data[b0 % 64], 64'hC1);
        chk("post_rst_d1", b_data[(b0 + 1) % 64], 64'hD1);
        chk("post_rst_last", {b_last[b0 % 64], b_last[(b0 + 1) % 64]}, 2'b01);
        chk("post_rst_err", wr_err, 0);

        chk("rinc_while_empty", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
